// File: rtl/id_ex_stage.sv
// ID/EX pipeline register.
// Captures decoder control, operands, immediate, PC and register indices for
// the EX stage. Detects load-use hazards against the instruction currently in
// EX, stalls IF/ID and inserts a bubble when one is found. A redirect from EX
// (flush) kills the decoding instruction. A saturating counter records every
// bubble inserted because of a load-use hazard.
module id_ex_stage #(
   parameter int XLEN      = 32,
   parameter int ALU_CTL_W = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_id_valid,
   input  logic [XLEN-1:0]      i_id_pc,
   input  logic [4:0]           i_id_rs1,
   input  logic [4:0]           i_id_rs2,
   input  logic [4:0]           i_id_rd,
   input  logic                 i_id_uses_rs1,
   input  logic                 i_id_uses_rs2,
   input  logic [XLEN-1:0]      i_id_rs1_data,
   input  logic [XLEN-1:0]      i_id_rs2_data,
   input  logic [XLEN-1:0]      i_id_imm,
   input  logic                 i_id_mem_rd,
   input  logic                 i_id_mem_wr,
   input  logic                 i_id_mem_to_reg,
   input  logic                 i_id_reg_wr,
   input  logic                 i_id_alu_src1,
   input  logic                 i_id_alu_src2,
   input  logic [ALU_CTL_W-1:0] i_id_alu_ctl,
   input  logic [2:0]           i_id_rw_type,
   input  logic                 i_flush,
   input  logic                 i_ex_hold,
   output logic                 o_stall,
   output logic                 o_ex_valid,
   output logic [XLEN-1:0]      o_ex_pc,
   output logic [4:0]           o_ex_rs1,
   output logic [4:0]           o_ex_rs2,
   output logic [4:0]           o_ex_rd,
   output logic                 o_ex_uses_rs1,
   output logic                 o_ex_uses_rs2,
   output logic [XLEN-1:0]      o_ex_rs1_data,
   output logic [XLEN-1:0]      o_ex_rs2_data,
   output logic [XLEN-1:0]      o_ex_imm,
   output logic                 o_ex_mem_rd,
   output logic                 o_ex_mem_wr,
   output logic                 o_ex_mem_to_reg,
   output logic                 o_ex_reg_wr,
   output logic                 o_ex_alu_src1,
   output logic                 o_ex_alu_src2,
   output logic [ALU_CTL_W-1:0] o_ex_alu_ctl,
   output logic [2:0]           o_ex_rw_type,
   output logic [CNT_W-1:0]     o_bubble_cnt
);

   // All captured fields travel as one bus so a bubble is a single all-zero load.
   localparam int BUS_W = 1 + 4 * XLEN + 15 + 2 + 6 + ALU_CTL_W + 3;

   logic [BUS_W-1:0] w_id_bus;
   logic [BUS_W-1:0] r_ex_bus;
   logic [CNT_W-1:0] r_bubble_cnt;
   logic             w_rs1_match;
   logic             w_rs2_match;
   logic             w_haz;
   logic             w_kill;
   logic             w_cnt_max;

   assign w_id_bus = {i_id_valid, i_id_pc, i_id_rs1, i_id_rs2, i_id_rd,
                      i_id_uses_rs1, i_id_uses_rs2, i_id_rs1_data, i_id_rs2_data,
                      i_id_imm, i_id_mem_rd, i_id_mem_wr, i_id_mem_to_reg,
                      i_id_reg_wr, i_id_alu_src1, i_id_alu_src2, i_id_alu_ctl,
                      i_id_rw_type};

   assign {o_ex_valid, o_ex_pc, o_ex_rs1, o_ex_rs2, o_ex_rd,
           o_ex_uses_rs1, o_ex_uses_rs2, o_ex_rs1_data, o_ex_rs2_data,
           o_ex_imm, o_ex_mem_rd, o_ex_mem_wr, o_ex_mem_to_reg,
           o_ex_reg_wr, o_ex_alu_src1, o_ex_alu_src2, o_ex_alu_ctl,
           o_ex_rw_type} = r_ex_bus;

   assign o_bubble_cnt = r_bubble_cnt;

   // Load-use hazard: a valid load in EX whose destination (not x0) is read by ID.
   // A bubble has ex_valid=0 and ex_mem_rd=0, so it can never raise a hazard.
   assign w_rs1_match = i_id_uses_rs1 & (i_id_rs1 == o_ex_rd);
   assign w_rs2_match = i_id_uses_rs2 & (i_id_rs2 == o_ex_rd);
   assign w_haz       = o_ex_valid & o_ex_mem_rd & (o_ex_rd != 5'd0) & i_id_valid
                        & (w_rs1_match | w_rs2_match);

   // A flush overrides the hazard: the dependent instruction is dead anyway,
   // so IF/ID must not be held for it.
   assign o_stall   = i_ex_hold | (w_haz & ~i_flush);
   assign w_kill    = i_flush | w_haz;
   assign w_cnt_max = &r_bubble_cnt;

   // Pipeline register: freeze on hold, bubble on flush/hazard, otherwise capture ID.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ex_bus <= '0;
      end else if (!i_ex_hold) begin
         r_ex_bus <= w_kill ? '0 : w_id_bus;
      end
   end

   // Count hazard bubbles only; flush bubbles and held cycles are not counted.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_bubble_cnt <= '0;
      end else if (!i_ex_hold && !i_flush && w_haz && !w_cnt_max) begin
         r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with a scoreboard of expected EX contents.
// A second instance with a 2-bit counter shares the stimulus for saturation.
module tb_id_ex_stage;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        u1;
      logic        u2;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic        mem_rd;
      logic        mem_wr;
      logic        mem_to_reg;
      logic        reg_wr;
      logic        src1;
      logic        src2;
      logic [3:0]  alu;
      logic [2:0]  rw;
   } id_t;

   typedef struct {
      id_t         ex;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   logic clk;
   logic rst;
   logic flush;
   logic hold;
   id_t  din;
   id_t  obs;
   id_t  obs_s;
   logic stall;
   logic stall_s;
   logic [15:0] cnt;
   logic [1:0]  cnt2;

   int total = 0;
   int bad   = 0;

   // Reference state
   id_t         m_ex;
   logic [15:0] m_cnt;
   logic [1:0]  m_cnt2;
   exp_t        sb[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   id_ex_stage #(.XLEN(32), .ALU_CTL_W(4), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_id_valid(din.valid), .i_id_pc(din.pc),
      .i_id_rs1(din.rs1), .i_id_rs2(din.rs2), .i_id_rd(din.rd),
      .i_id_uses_rs1(din.u1), .i_id_uses_rs2(din.u2),
      .i_id_rs1_data(din.d1), .i_id_rs2_data(din.d2), .i_id_imm(din.imm),
      .i_id_mem_rd(din.mem_rd), .i_id_mem_wr(din.mem_wr),
      .i_id_mem_to_reg(din.mem_to_reg), .i_id_reg_wr(din.reg_wr),
      .i_id_alu_src1(din.src1), .i_id_alu_src2(din.src2),
      .i_id_alu_ctl(din.alu), .i_id_rw_type(din.rw),
      .i_flush(flush), .i_ex_hold(hold),
      .o_stall(stall),
      .o_ex_valid(obs.valid), .o_ex_pc(obs.pc),
      .o_ex_rs1(obs.rs1), .o_ex_rs2(obs.rs2), .o_ex_rd(obs.rd),
      .o_ex_uses_rs1(obs.u1), .o_ex_uses_rs2(obs.u2),
      .o_ex_rs1_data(obs.d1), .o_ex_rs2_data(obs.d2), .o_ex_imm(obs.imm),
      .o_ex_mem_rd(obs.mem_rd), .o_ex_mem_wr(obs.mem_wr),
      .o_ex_mem_to_reg(obs.mem_to_reg), .o_ex_reg_wr(obs.reg_wr),
      .o_ex_alu_src1(obs.src1), .o_ex_alu_src2(obs.src2),
      .o_ex_alu_ctl(obs.alu), .o_ex_rw_type(obs.rw),
      .o_bubble_cnt(cnt)
   );

   id_ex_stage #(.XLEN(32), .ALU_CTL_W(4), .CNT_W(2)) dut_s (
      .i_clk(clk), .i_rst(rst),
      .i_id_valid(din.valid), .i_id_pc(din.pc),
      .i_id_rs1(din.rs1), .i_id_rs2(din.rs2), .i_id_rd(din.rd),
      .i_id_uses_rs1(din.u1), .i_id_uses_rs2(din.u2),
      .i_id_rs1_data(din.d1), .i_id_rs2_data(din.d2), .i_id_imm(din.imm),
      .i_id_mem_rd(din.mem_rd), .i_id_mem_wr(din.mem_wr),
      .i_id_mem_to_reg(din.mem_to_reg), .i_id_reg_wr(din.reg_wr),
      .i_id_alu_src1(din.src1), .i_id_alu_src2(din.src2),
      .i_id_alu_ctl(din.alu), .i_id_rw_type(din.rw),
      .i_flush(flush), .i_ex_hold(hold),
      .o_stall(stall_s),
      .o_ex_valid(obs_s.valid), .o_ex_pc(obs_s.pc),
      .o_ex_rs1(obs_s.rs1), .o_ex_rs2(obs_s.rs2), .o_ex_rd(obs_s.rd),
      .o_ex_uses_rs1(obs_s.u1), .o_ex_uses_rs2(obs_s.u2),
      .o_ex_rs1_data(obs_s.d1), .o_ex_rs2_data(obs_s.d2), .o_ex_imm(obs_s.imm),
      .o_ex_mem_rd(obs_s.mem_rd), .o_ex_mem_wr(obs_s.mem_wr),
      .o_ex_mem_to_reg(obs_s.mem_to_reg), .o_ex_reg_wr(obs_s.reg_wr),
      .o_ex_alu_src1(obs_s.src1), .o_ex_alu_src2(obs_s.src2),
      .o_ex_alu_ctl(obs_s.alu), .o_ex_rw_type(obs_s.rw),
      .o_bubble_cnt(cnt2)
   );

   task automatic chk(input string tag, input logic [191:0] o, input logic [191:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Instruction builder: random payload, directed register fields
   function automatic id_t mk(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic u1, input logic u2,
                              input logic mrd);
      id_t t;
      t.valid      = v;
      t.pc         = $urandom;
      t.rs1        = rs1;
      t.rs2        = rs2;
      t.rd         = rd;
      t.u1         = u1;
      t.u2         = u2;
      t.d1         = $urandom;
      t.d2         = $urandom;
      t.imm        = $urandom;
      t.mem_rd     = mrd;
      t.mem_wr     = 1'(mrd ? 1'b0 : 1'($urandom_range(0, 1)));
      t.mem_to_reg = mrd;
      t.reg_wr     = 1'b1;
      t.src1       = 1'($urandom_range(0, 1));
      t.src2       = 1'($urandom_range(0, 1));
      t.alu        = 4'($urandom_range(0, 15));
      t.rw         = 3'($urandom_range(0, 7));
      return t;
   endfunction

   function automatic logic m_haz(input id_t ex, input id_t id);
      return ex.valid && ex.mem_rd && (ex.rd != 5'd0) && id.valid &&
             ((id.u1 && id.rs1 == ex.rd) || (id.u2 && id.rs2 == ex.rd));
   endfunction

   // One cycle: drive ID, check stall before the edge, push expectation, check after the edge.
   task automatic step(input string tag, input id_t in, input logic fl, input logic hd,
                       output logic stall_seen);
      logic h;
      exp_t e;
      din   = in;
      flush = fl;
      hold  = hd;
      #1;
      h = m_haz(m_ex, in);
      stall_seen = stall;
      chk({tag, "_stall"}, 192'(stall), 192'(hd | (h & ~fl)));
      if (!hd) begin
         if (fl) begin
            m_ex = '0;
         end else if (h) begin
            m_ex = '0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
         end else begin
            m_ex = in;
         end
      end
      e.ex   = m_ex;
      e.cnt  = m_cnt;
      e.cnt2 = m_cnt2;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, "_ex"}, 192'(obs), 192'(e.ex));
      chk({tag, "_cnt"}, 192'(cnt), 192'(e.cnt));
      chk({tag, "_cnt2"}, 192'(cnt2), 192'(e.cnt2));
      $display("step %s: in_valid=%0d flush=%0d hold=%0d stall=%0d ex_valid=%0d ex_rd=%0d cnt=%0d cnt2=%0d",
               tag, in.valid, fl, hd, stall_seen, obs.valid, obs.rd, cnt, cnt2);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before the next edge.
   task automatic async_reset(input string tag);
      logic s;
      #3;
      rst = 1'b1;
      #1;
      chk({tag, "_ex0"}, 192'(obs), 192'(0));
      chk({tag, "_cnt0"}, 192'(cnt), 192'(0));
      chk({tag, "_cnt20"}, 192'(cnt2), 192'(0));
      chk({tag, "_stall0"}, 192'(stall), 192'(0));
      m_ex   = '0;
      m_cnt  = '0;
      m_cnt2 = '0;
      @(posedge clk);
      #2;
      din   = '0;
      flush = 1'b0;
      hold  = 1'b0;
      rst   = 1'b0;
      step({tag, "_rel"}, '0, 1'b0, 1'b0, s);
      chk({tag, "_valid_after"}, 192'(obs.valid), 192'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      id_t lw5, lw0, add, use0, nouse, other;
      logic s;
      rst    = 1'b0;
      flush  = 1'b0;
      hold   = 1'b0;
      din    = '0;
      m_ex   = '0;
      m_cnt  = '0;
      m_cnt2 = '0;
      #1;
      rst = 1'b1;
      #1;
      chk("por_ex", 192'(obs), 192'(0));
      chk("por_cnt", 192'(cnt), 192'(0));
      @(posedge clk);
      #2;
      rst = 1'b0;
      step("por_first", '0, 1'b0, 1'b0, s);
      chk("por_valid", 192'(obs.valid), 192'(0));

      lw5   = mk(1'b1, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
      add   = mk(1'b1, 5'd6, 5'd5, 5'd7, 1'b1, 1'b1, 1'b0);
      lw0   = mk(1'b1, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
      use0  = mk(1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
      nouse = mk(1'b1, 5'd10, 5'd3, 5'd5, 1'b1, 1'b0, 1'b0);
      other = mk(1'b1, 5'd11, 5'd12, 5'd13, 1'b1, 1'b1, 1'b0);

      // Load-use: one bubble, then the add loads
      step("t2_lw", lw5, 1'b0, 1'b0, s);
      chk("t2_lw_rd", 192'(obs.rd), 192'(5));
      step("t2_haz", add, 1'b0, 1'b0, s);
      chk("t2_haz_stall", 192'(s), 192'(1));
      chk("t2_haz_bubble", 192'(obs.valid), 192'(0));
      chk("t2_haz_cnt", 192'(cnt), 192'(1));
      step("t2_replay", add, 1'b0, 1'b0, s);
      chk("t2_replay_stall", 192'(s), 192'(0));
      chk("t2_replay_rd", 192'(obs.rd), 192'(6));
      chk("t2_replay_data", 192'(obs.d1), 192'(add.d1));

      // x0 destination and unused rs2 never hazard
      step("t3_lw0", lw0, 1'b0, 1'b0, s);
      step("t3_use0", use0, 1'b0, 1'b0, s);
      chk("t3_use0_stall", 192'(s), 192'(0));
      chk("t3_use0_valid", 192'(obs.valid), 192'(1));
      step("t3_lw5", lw5, 1'b0, 1'b0, s);
      step("t3_nouse", nouse, 1'b0, 1'b0, s);
      chk("t3_nouse_stall", 192'(s), 192'(0));
      chk("t3_nouse_rd", 192'(obs.rd), 192'(10));
      chk("t3_cnt", 192'(cnt), 192'(1));

      // Invalid ID is loaded as invalid and never hazards
      step("t3_lw5b", lw5, 1'b0, 1'b0, s);
      step("t3_inv", mk(1'b0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0, s);
      chk("t3_inv_stall", 192'(s), 192'(0));

      // Hazard and flush together
      step("t4_lw", lw5, 1'b0, 1'b0, s);
      step("t4_flush", add, 1'b1, 1'b0, s);
      chk("t4_stall", 192'(s), 192'(0));
      chk("t4_bubble", 192'(obs.valid), 192'(0));
      chk("t4_cnt", 192'(cnt), 192'(1));

      // Hold with flush and hazard: frozen, stall high; then flush bubble
      step("t5_lw", lw5, 1'b0, 1'b0, s);
      for (int i = 0; i < 3; i++) begin
         step("t5_hold", add, 1'b1, 1'b1, s);
         chk("t5_hold_stall", 192'(s), 192'(1));
         chk("t5_hold_frozen", 192'(obs), 192'(lw5));
      end
      step("t5_release", add, 1'b1, 1'b0, s);
      chk("t5_release_stall", 192'(s), 192'(0));
      chk("t5_release_bubble", 192'(obs), 192'(0));
      chk("t5_cnt", 192'(cnt), 192'(1));

      // Async reset while a stall is pending
      step("t1_other", other, 1'b0, 1'b0, s);
      step("t1_lw", lw5, 1'b0, 1'b0, s);
      din = add;
      #1;
      chk("t1_prestall", 192'(stall), 192'(1));
      async_reset("t1");

      // Saturation of the 2-bit counter
      for (int i = 0; i < 5; i++) begin
         step("t6_lw", lw5, 1'b0, 1'b0, s);
         step("t6_haz", add, 1'b0, 1'b0, s);
      end
      chk("t6_cnt2_sat", 192'(cnt2), 192'(3));
      chk("t6_cnt16", 192'(cnt), 192'(5));
      chk("t6_sb_empty", 192'(sb.size()), 192'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
